// File: rtl/sync_receiver_if.sv
// Signal bundle between the remote sync line / control registers and sync_receiver.
interface sync_receiver_if;
  logic        sync_in;
  logic [15:0] timeout_reg;
  logic        rearm;
  logic        start_strobe;
  logic        sync_locked;
  logic        sync_timeout;
  logic        sync_lost;
  logic [15:0] arrival_time;

  modport master (
    output sync_in, timeout_reg, rearm,
    input  start_strobe, sync_locked, sync_timeout, sync_lost, arrival_time
  );

  modport slave (
    input  sync_in, timeout_reg, rearm,
    output start_strobe, sync_locked, sync_timeout, sync_lost, arrival_time
  );
endinterface

// File: rtl/sync_receiver.sv
// Start-sync receiver: synchronizes and debounces the remote sync line, strobes once on
// the qualified rising edge after arming, and reports arrival time, timeout and loss of sync.
module sync_receiver #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  sync_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    LOCKED,
    TIMEOUT
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic        s1;
  logic        s2;
  logic        filt;
  logic [3:0]  cnt;

  state_t      state;
  state_t      state_d;
  logic [15:0] elapsed;
  logic [15:0] elapsed_d;
  logic [15:0] tmo;
  logic [15:0] tmo_d;
  logic [15:0] arrival;
  logic [15:0] arrival_d;
  logic        strobe;
  logic        strobe_d;
  logic        locked;
  logic        locked_d;
  logic        timed_out;
  logic        timed_out_d;
  logic        lost;
  logic        lost_d;

  // The filtered level starts high so a line already asserted at reset never looks like a new edge.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      s1 <= bus.sync_in;
      s2 <= s1;
      if (s2 != filt) begin
        if (cnt == CNT_MAX) begin
          filt <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    elapsed_d   = elapsed;
    tmo_d       = tmo;
    arrival_d   = arrival;
    strobe_d    = 1'b0;
    locked_d    = locked;
    timed_out_d = timed_out;
    lost_d      = lost;

    if (bus.rearm) begin
      state_d     = WAIT_LOW;
      elapsed_d   = '0;
      arrival_d   = '0;
      locked_d    = 1'b0;
      timed_out_d = 1'b0;
      lost_d      = 1'b0;
    end else begin
      case (state)
        WAIT_LOW: begin
          if (!filt) begin
            state_d   = ARMED;
            elapsed_d = '0;
            tmo_d     = bus.timeout_reg;
          end
        end
        ARMED: begin
          if (elapsed != 16'hFFFF) elapsed_d = elapsed + 16'd1;
          // An edge arriving in the last allowed cycle still wins over the timeout.
          if (filt) begin
            state_d   = LOCKED;
            strobe_d  = 1'b1;
            locked_d  = 1'b1;
            arrival_d = elapsed;
          end else if ((tmo != 16'd0) && (elapsed == tmo - 16'd1)) begin
            state_d     = TIMEOUT;
            timed_out_d = 1'b1;
          end
        end
        LOCKED: begin
          if (!filt) lost_d = 1'b1;
        end
        TIMEOUT: begin
          state_d = TIMEOUT;
        end
        default: begin
          state_d = WAIT_LOW;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_LOW;
      elapsed   <= '0;
      tmo       <= '0;
      arrival   <= '0;
      strobe    <= 1'b0;
      locked    <= 1'b0;
      timed_out <= 1'b0;
      lost      <= 1'b0;
    end else begin
      state     <= state_d;
      elapsed   <= elapsed_d;
      tmo       <= tmo_d;
      arrival   <= arrival_d;
      strobe    <= strobe_d;
      locked    <= locked_d;
      timed_out <= timed_out_d;
      lost      <= lost_d;
    end
  end

  assign bus.start_strobe = strobe;
  assign bus.sync_locked  = locked;
  assign bus.sync_timeout = timed_out;
  assign bus.sync_lost    = lost;
  assign bus.arrival_time = arrival;

endmodule
